// File: rtl/prince_bwd_rounds.sv
// PRINCE backward half: inverse rounds R6^-1..R10^-1, one per clock, then the final RC11 ^ k1 addition.
// Optional build macro PRINCE_BWD_DEC_EN adds a `dec` input that loads k1 ^ alpha for decryption.

module linear_m_inv (
  input  logic [63:0] din,
  output logic [63:0] dout
);
  logic [63:0] sr;

  // Diagonal of block M_i inside M-hat: identity with nibble bit i cleared (bit 0 = nibble MSB).
  function automatic logic [3:0] blk_mask(input int idx);
    case (idx % 4)
      0:       return 4'h7;
      1:       return 4'hB;
      2:       return 4'hD;
      default: return 4'hE;
    endcase
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch can be inferred.
    sr   = '0;
    dout = '0;
    // Inverse ShiftRows: output nibble i takes input nibble 13*i mod 16.
    for (int i = 0; i < 16; i++)
      sr[63-4*i -: 4] = din[63-4*((13*i)%16) -: 4];
    // M' = diag(M-hat0, M-hat1, M-hat1, M-hat0) over 16-bit chunks, chunk 0 = bits [63:48].
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++)
          dout[63-16*c-4*j -: 4] = dout[63-16*c-4*j -: 4]
            ^ (sr[63-16*c-4*k -: 4] & blk_mask(j + k + ((c == 1 || c == 2) ? 1 : 0)));
  end
endmodule

module prince_bwd_rounds (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] din,
  input  logic [63:0] k1,
`ifdef PRINCE_BWD_DEC_EN
  input  logic        dec,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] dout
);
  localparam logic [63:0] RC11 = 64'hc0ac29b7c97c50dd;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t        fsm;
  logic [2:0]  cnt;
  logic [63:0] state_q;
  logic [63:0] key_q;
  logic [63:0] key_in;
  logic [63:0] rc;
  logic [63:0] mix;
  logic [63:0] sub;

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: return 4'hB;  4'h1: return 4'h7;  4'h2: return 4'h3;  4'h3: return 4'h2;
      4'h4: return 4'hF;  4'h5: return 4'hD;  4'h6: return 4'h8;  4'h7: return 4'h9;
      4'h8: return 4'hA;  4'h9: return 4'h6;  4'hA: return 4'h4;  4'hB: return 4'h0;
      4'hC: return 4'h5;  4'hD: return 4'hE;  4'hE: return 4'hC;  default: return 4'h1;
    endcase
  endfunction

`ifdef PRINCE_BWD_DEC_EN
  localparam logic [63:0] ALPHA = 64'hc0ac29b7c97c50dd;
  assign key_in = dec ? (k1 ^ ALPHA) : k1;
`else
  assign key_in = k1;
`endif

  always_comb begin
    case (cnt)
      3'd0:    rc = 64'h7ef84f78fd955cb1;
      3'd1:    rc = 64'h85840851f1ac43aa;
      3'd2:    rc = 64'hc882d32f25323c54;
      3'd3:    rc = 64'h64a51195e0e3610d;
      3'd4:    rc = 64'hd3b5a399ca0c2399;
      default: rc = '0;
    endcase
  end

  linear_m_inv u_m_inv (
    .din  (state_q ^ key_q ^ rc),
    .dout (mix)
  );

  always_comb begin
    sub = '0;
    for (int i = 0; i < 16; i++)
      sub[63-4*i -: 4] = sbox_inv(mix[63-4*i -: 4]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      cnt       <= '0;
      state_q   <= '0;
      key_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      unique case (fsm)
        IDLE: begin
          if (in_valid) begin
            state_q  <= din;
            key_q    <= key_in;
            cnt      <= '0;
            in_ready <= 1'b0;
            fsm      <= RUN;
          end
        end
        RUN: begin
          if (cnt == 3'd4) begin
            state_q   <= sub ^ key_q ^ RC11;
            cnt       <= '0;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            state_q <= sub;
            cnt     <= cnt + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign dout = state_q;
endmodule
